// File: rtl/ram_share_arbiter.sv
// Two-master round-robin arbiter and access sequencer for a single-port RAM.
// One access in flight at a time; every output comes straight from a register.
module ram_share_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              last_owner,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RWAIT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_busy;
  logic                r_last_owner;

  logic                w_gnt0_nxt;
  logic                w_gnt1_nxt;
  logic                w_rvalid0_nxt;
  logic                w_rvalid1_nxt;
  logic [DATA_W-1:0]   w_rdata0_nxt;
  logic [DATA_W-1:0]   w_rdata1_nxt;
  logic                w_ram_we_nxt;
  logic [ADDR_W-1:0]   w_ram_addr_nxt;
  logic [DATA_W-1:0]   w_ram_din_nxt;
  logic                w_last_owner_nxt;
  logic                w_any_req;
  logic                w_winner;

  // Handshake: a master raises req with stable we/addr/wdata and holds it until
  // it sees its gnt pulse; req is only looked at in IDLE and is never queued.
  assign w_any_req = m0_req | m1_req;
  assign w_winner  = (m0_req & m1_req) ? ~r_last_owner : m1_req;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_gnt0_nxt       = 1'b0;
    w_gnt1_nxt       = 1'b0;
    w_rvalid0_nxt    = 1'b0;
    w_rvalid1_nxt    = 1'b0;
    w_rdata0_nxt     = r_rdata0;
    w_rdata1_nxt     = r_rdata1;
    w_ram_we_nxt     = 1'b0;
    w_ram_addr_nxt   = r_ram_addr;
    w_ram_din_nxt    = r_ram_din;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt      = XFER;
          w_gnt0_nxt       = ~w_winner;
          w_gnt1_nxt       = w_winner;
          w_ram_we_nxt     = w_winner ? m1_we    : m0_we;
          w_ram_addr_nxt   = w_winner ? m1_addr  : m0_addr;
          w_ram_din_nxt    = w_winner ? m1_wdata : m0_wdata;
          w_last_owner_nxt = w_winner;
        end
      end
      XFER: begin
        // r_ram_we still carries the operation type the RAM samples this edge
        if (r_ram_we) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RWAIT;
          w_cnt_nxt   = CNT_W'(RD_LAT - 1);
        end
      end
      RWAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          if (r_last_owner) begin
            w_rvalid1_nxt = 1'b1;
            w_rdata1_nxt  = ram_dout;
          end else begin
            w_rvalid0_nxt = 1'b1;
            w_rdata0_nxt  = ram_dout;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_busy       <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt0       <= w_gnt0_nxt;
      r_gnt1       <= w_gnt1_nxt;
      r_rvalid0    <= w_rvalid0_nxt;
      r_rvalid1    <= w_rvalid1_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_rdata1     <= w_rdata1_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_din    <= w_ram_din_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_last_owner <= w_last_owner_nxt;
    end
  end

  assign m0_gnt     = r_gnt0;
  assign m1_gnt     = r_gnt1;
  assign m0_rvalid  = r_rvalid0;
  assign m1_rvalid  = r_rvalid1;
  assign m0_rdata   = r_rdata0;
  assign m1_rdata   = r_rdata1;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_din    = r_ram_din;
  assign busy       = r_busy;
  assign last_owner = r_last_owner;
  assign dbg_state  = r_state;

endmodule

// File: doc/ram_share_arbiter.md
Name: ram_share_arbiter

Overview:
Two-master arbiter and sequencer for the single-port data RAM (10-bit word address, 32-bit data).
- Master 0 is the CPU-side bus path (address decoder). Master 1 is a secondary requester, e.g. a DMA or debug/monitor port.
- The block grants one access at a time with round-robin fairness.
- It drives the RAM port and returns read data to the winning master after the RAM read latency.
- It sits between the bus decoder and the RAM instance, in the fast clock domain.

Parameters:
ADDR_W, 10, RAM word-address width
DATA_W, 32, RAM data width
RD_LAT, 1, RAM read latency in clock edges from address sampled to dout valid (legal 1..4)

Ports:
clk  in  1  system clock; the RAM is clocked by the same clk
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 request; held with stable we/addr/wdata until m0_gnt sampled high
m0_we  in  1  master 0: 1=write, 0=read
m0_addr  in  ADDR_W  master 0 word address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  one-cycle pulse; request accepted
m0_rvalid  out  1  one-cycle pulse; m0_rdata valid
m0_rdata  out  DATA_W  read data to master 0
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions, widths and meanings as the m0_* ports, for master 1
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data
busy  out  1  high whenever state != IDLE
last_owner  out  1  index of the master most recently granted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values: state=IDLE; all gnt, rvalid, ram_we and busy outputs 0; ram_addr, ram_din, m0_rdata, m1_rdata 0; last_owner=1, so master 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, XFER, RWAIT.
- IDLE, no request: stay in IDLE.
- IDLE, any request sampled at edge k:
  - Pick the winner: a single requester wins; if both request, the master != last_owner wins.
  - At edge k, register ram_addr/ram_din/ram_we from the winner, set the winner's gnt=1, set last_owner=winner, go to XFER.
- XFER (exactly one cycle):
  - The RAM samples the operation at edge k+1.
  - At edge k+1: gnt←0, ram_we←0 (ram_addr and ram_din are held).
  - Write: go to IDLE. Read: go to RWAIT and load the wait counter.
- RWAIT: stay for RD_LAT edges after edge k+1 (RD_LAT=1 means one edge).
  - At edge k+1+RD_LAT: capture ram_dout into the owner's rdata, pulse the owner's rvalid for one cycle, go to IDLE.
- Latency:
  - Write: gnt-high to next-grant opportunity is 2 cycles.
  - Read: rvalid goes high RD_LAT+1 cycles after gnt goes high.
- Throughput: at most one access per 2 cycles (writes) or per RD_LAT+2 cycles (reads).
- Requests and gnt:
  - Requests are ignored outside IDLE; they are not queued internally.
  - A requester must hold req until it samples gnt high.
  - A requester that drops req before grant is simply not served; no error is raised.
- Fairness: with both masters continuously requesting, grants strictly alternate. Maximum wait is one foreign access.
- The rdata of the non-owning master is unchanged by the other master's read.
- Reset mid-operation (XFER or RWAIT): the pending read is discarded, no rvalid is issued, ram_we goes to 0 immediately, and all reset values apply.
- Simultaneous gnt and a new req from the same master in XFER: the new req is ignored until IDLE.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs 0, busy=0, last_owner=1.
- Master 0 write then read, RD_LAT=1:
  - Write addr 0x005, data 0xDEADBEEF -> ram_we=1 for exactly 1 cycle with ram_addr=0x005, ram_din=0xDEADBEEF; m0_gnt 1-cycle pulse.
  - Then read 0x005 -> m0_rvalid pulses 2 cycles after m0_gnt with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Both masters request continuously after reset -> grant order m0, m1, m0, m1; each gnt is exactly one cycle; last_owner toggles.
- m1 issues back-to-back writes alone -> m1_gnt every 2 cycles. m0 asserts req mid-stream -> m0 is granted at the next IDLE, before m1's next write.
- RD_LAT=3 build: m1 reads 0x3FF holding 0x12345678 -> m1_rvalid 4 cycles after m1_gnt, data 0x12345678, busy high throughout.
- rst asserted during RWAIT of an m0 read -> no m0_rvalid ever appears. A subsequent m1 request is granted normally and m0 wins the next tie.
